// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP neuron datapath: FSM state encoding,
// fixed-point scale constant and the ReLU + rescale step.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    BIAS,
    ACT,
    OUT
  } neuron_state_t;

  localparam int PKG_FRAC_W = 8;
  localparam int Q_ONE      = 1 << PKG_FRAC_W;

  // Width the rescale helper works in; any accumulator up to this width fits.
  localparam int RESCALE_W = 64;

  // Negative sums clamp to zero, the rest drop their fractional bits.
  function automatic logic signed [RESCALE_W-1:0] relu_rescale(
    input logic signed [RESCALE_W-1:0] acc,
    input int unsigned                 frac_w
  );
    if (acc < 0) return '0;
    return acc >>> frac_w;
  endfunction

endpackage

// File: rtl/neuron_mac_accum.sv
// Signed multiply-accumulate core: full-width product, ACC_W accumulator with
// clear, add-product and add-bias controls (clear has priority).
module neuron_mac_accum #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     add_product,
  input  logic                     add_bias,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    product_ext;
  logic signed [ACC_W-1:0]    bias_ext;

  assign product     = weight * x_in;
  assign product_ext = ACC_W'(product);
  // Bias is aligned to the product's 2*FRAC_W binary point.
  assign bias_ext    = ACC_W'(bias) <<< FRAC_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_product) begin
      acc <= acc + product_ext;
    end else if (add_bias) begin
      acc <= acc + bias_ext;
    end
  end

endmodule

// File: rtl/neuron_mac_datapath.sv
// One MLP neuron: sum(w*x) + bias, ReLU, rescale, valid/ready output.
// Define MLP_NEURON_SAT_EN to clamp oversized results and flag overflow.
module neuron_mac_datapath
  import mlp_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int NUM_INPUTS = 8,
  parameter int ACC_W      = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);
  localparam logic signed [RESCALE_W-1:0] RES_MAX =
    (RESCALE_W'(1) <<< (DATA_W - 1)) - RESCALE_W'(1);

  neuron_state_t           state;
  logic [CNT_W-1:0]        count;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [ACC_W-1:0] acc;
  logic                    clear_acc;
  logic                    add_product;
  logic                    add_bias;
  logic signed [RESCALE_W-1:0] r;
  logic [DATA_W:0]         sat_r;

  // Returns {overflow, data}; without saturation the result simply wraps.
  function automatic logic [DATA_W:0] saturate(input logic signed [RESCALE_W-1:0] v);
`ifdef MLP_NEURON_SAT_EN
    if (v > RES_MAX) return {1'b1, RES_MAX[DATA_W-1:0]};
    return {1'b0, v[DATA_W-1:0]};
`else
    return {1'b0, v[DATA_W-1:0]};
`endif
  endfunction

  assign clear_acc   = (state == IDLE) && start;
  assign add_product = (state == ACCUM) && in_valid && in_ready;
  assign add_bias    = (state == BIAS);

  neuron_mac_accum #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_accum (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_acc),
    .add_product (add_product),
    .add_bias    (add_bias),
    .weight      (weight),
    .x_in        (x_in),
    .bias        (bias_q),
    .acc         (acc)
  );

  assign r     = relu_rescale(RESCALE_W'(acc), FRAC_W);
  assign sat_r = saturate(r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      bias_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bias_q   <= bias;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            count <= count + 1'b1;
            if (count == LAST_IDX) begin
              in_ready <= 1'b0;
              state    <= BIAS;
            end
          end
        end
        BIAS: begin
          state <= ACT;
        end
        // Result and flag are frozen here and held through the OUT wait.
        ACT: begin
          out_data  <= sat_r[DATA_W-1:0];
          overflow  <= sat_r[DATA_W];
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_datapath.sv
// Scoreboard bench for neuron_mac_datapath: directed cases plus random neurons
// checked against an integer reference model.
module tb_neuron_mac_datapath;
  import mlp_pkg::Q_ONE;

  localparam int DATA_W     = 16;
  localparam int FRAC_W     = 8;
  localparam int NUM_INPUTS = 4;
  localparam int ACC_W      = 40;

  typedef logic signed [DATA_W-1:0] vec_t [NUM_INPUTS];
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [DATA_W-1:0] bias = '0;
  logic signed [DATA_W-1:0] weight = '0;
  logic signed [DATA_W-1:0] x_in = '0;
  logic in_ready, out_valid, busy, done, overflow;
  logic [DATA_W-1:0] out_data;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  bit expect_done = 1'b0;

  vec_t c1w = '{16'sd256, 16'sd256, 16'sd256, 16'sd256};
  vec_t c1x = '{16'sd256, 16'sd512, 16'sd768, 16'sd1024};
  vec_t c2w = '{-16'sd256, -16'sd256, -16'sd256, -16'sd256};
  vec_t c2x = '{16'sd256, 16'sd256, 16'sd256, 16'sd256};
  vec_t c4v = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};

  always #5 clk = ~clk;

  neuron_mac_datapath #(
    .DATA_W     (DATA_W),
    .FRAC_W     (FRAC_W),
    .NUM_INPUTS (NUM_INPUTS),
    .ACC_W      (ACC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .weight    (weight),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: exact integer sum, bias scaled to the product's binary point.
  function automatic exp_t model(input logic signed [DATA_W-1:0] b,
                                 input vec_t w, input vec_t x);
    longint s;
    longint r;
    longint max_pos;
    exp_t e;
    max_pos = (longint'(1) << (DATA_W - 1)) - 1;
    s = longint'(b) * Q_ONE;
    for (int i = 0; i < NUM_INPUTS; i++) s += longint'(w[i]) * longint'(x[i]);
    r = (s < 0) ? 0 : s / Q_ONE;
`ifdef MLP_NEURON_SAT_EN
    if (r > max_pos) begin
      e.data = DATA_W'(max_pos);
      e.ovf  = 1'b1;
    end else begin
      e.data = r[DATA_W-1:0];
      e.ovf  = 1'b0;
    end
`else
    e.data = r[DATA_W-1:0];
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: checks every output handshake and the done pulse after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        expect_done = 1'b0;
      end else begin
        if (expect_done || done) check("done_pulse", done, expect_done);
        expect_done = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got out_data=%0d, expected no result", out_data);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("overflow", overflow, e.ovf);
          end
          expect_done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_neuron(input logic signed [DATA_W-1:0] b, input vec_t w, input vec_t x);
    int n;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    if (busy) fail_now("idle_wait");
    sb.push_back(model(b, w, x));
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input vec_t w, input vec_t x, input int npairs,
                      input bit gaps, input bit poke_start);
    int n;
    bit taken;
    for (int i = 0; i < npairs; i++) begin
      if (gaps && i > 0) begin in_valid = 1'b0; tick(); end
      in_valid = 1'b1;
      weight   = w[i];
      x_in     = x[i];
      if (poke_start && i == 1) start = 1'b1;
      n = 0;
      taken = 1'b0;
      while (!taken && n < 50) begin
        taken = in_ready;
        tick();
        start = 1'b0;
        n++;
      end
      if (!taken) fail_now("in_ready_wait");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int hold);
    int n;
    logic [DATA_W-1:0] held;
    if (hold > 0) begin
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      if (!out_valid) fail_now("out_valid_wait");
      held = out_data;
      for (int k = 0; k < hold; k++) begin
        tick();
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held);
      end
      out_ready = 1'b1;
    end
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) fail_now("out_valid_wait");
    tick();
    check("valid_drop", out_valid, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    vec_t rw;
    vec_t rx;
    logic signed [DATA_W-1:0] rb;

    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Directed cases
    begin_neuron(16'sd0, c1w, c1x);   feed(c1w, c1x, NUM_INPUTS, 1'b0, 1'b0); drain(0);
    begin_neuron(16'sd0, c2w, c2x);   feed(c2w, c2x, NUM_INPUTS, 1'b0, 1'b0); drain(0);
    begin_neuron(16'sd128, c1w, c1x); feed(c1w, c1x, NUM_INPUTS, 1'b1, 1'b0); drain(5);
    begin_neuron(16'sd32767, c4v, c4v); feed(c4v, c4v, NUM_INPUTS, 1'b0, 1'b0); drain(0);

    // Abort a neuron part-way with reset; nothing is expected from it.
    start = 1'b1;
    bias  = 16'sd0;
    tick();
    start = 1'b0;
    feed(c1w, c1x, 2, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    tick();
    check_idle_outputs("midreset_cyc");
    reset = 1'b0;
    tick();
    begin_neuron(16'sd0, c1w, c1x); feed(c1w, c1x, NUM_INPUTS, 1'b0, 1'b0); drain(0);

    // Stray start during ACCUM, then back-to-back neurons off the done cycle.
    begin_neuron(16'sd0, c1w, c1x); feed(c1w, c1x, NUM_INPUTS, 1'b0, 1'b1); drain(0);
    begin_neuron(16'sd0, c1w, c1x); feed(c1w, c1x, NUM_INPUTS, 1'b0, 1'b0); drain(0);
    check("b2b_done_cycle", done, 1);
    begin_neuron(16'sd128, c1w, c1x);
    check("b2b_in_ready", in_ready, 1);
    feed(c1w, c1x, NUM_INPUTS, 1'b0, 1'b0);
    drain(0);

    // Random neurons over the full operand range
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        rw[i] = DATA_W'($urandom());
        rx[i] = (t < 12) ? DATA_W'($urandom_range(0, 1023)) : DATA_W'($urandom());
      end
      rb = DATA_W'($urandom());
      begin_neuron(rb, rw, rx);
      feed(rw, rx, NUM_INPUTS, 1'($urandom_range(0, 1)), 1'b0);
      drain($urandom_range(0, 3));
    end

    repeat (4) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
